// File: rtl/reg_dump_display.sv
// Register-file dump sequencer: steps a register file out to LEDs chunk by chunk on step_tick
// and drives an 8-digit multiplexed 7-segment display. Define REG_DUMP_LOOP_EN to repeat the dump forever.
module reg_dump_display #(
  parameter int DATA_W   = 32,
  parameter int LED_W    = 16,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_tick,
  input  logic              pause,
  input  logic              done,
  input  logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        anode,
  output logic [6:0]        cathode,
  output logic              dp
);

  localparam int CHUNKS  = DATA_W / LED_W;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IDLE, MARK, LOAD, SHOW, FIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [CHUNK_W-1:0]  r_chunk, w_chunk_nxt, w_chunk_dn;
  logic [LED_W-1:0]    r_led, w_led_nxt;
  logic                w_tick;

  assign w_tick     = step_tick & ~pause;
  assign w_chunk_dn = r_chunk - CHUNK_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_chunk <= '0;
      r_led   <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_chunk <= w_chunk_nxt;
      r_led   <= w_led_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_chunk_nxt = r_chunk;
    w_led_nxt   = r_led;
    if (!done) begin
      // Losing done aborts the dump from any state; the register file may be changing.
      w_state_nxt = IDLE;
      w_addr_nxt  = '0;
      w_chunk_nxt = '0;
      w_led_nxt   = '1;
    end else begin
      case (r_state)
        IDLE: begin
          w_led_nxt = '1;
          if (w_tick) w_state_nxt = MARK;
        end
        MARK: begin
          w_led_nxt = '1;
          if (w_tick) begin
            w_state_nxt = LOAD;
            w_addr_nxt  = '0;
          end
        end
        LOAD: begin
          // reg_addr settled last clk, so reg_data is valid now regardless of pause.
          w_led_nxt   = reg_data[DATA_W-1 -: LED_W];
          w_chunk_nxt = CHUNK_W'(CHUNKS - 1);
          w_state_nxt = SHOW;
        end
        SHOW: begin
          if (w_tick) begin
            if (CHUNKS > 1 && r_chunk != '0) begin
              w_chunk_nxt = w_chunk_dn;
              w_led_nxt   = reg_data[w_chunk_dn*LED_W +: LED_W];
            end else if (r_addr != ADDR_W'(NREGS - 1)) begin
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_state_nxt = LOAD;
            end else begin
`ifdef REG_DUMP_LOOP_EN
              w_addr_nxt  = '0;
              w_state_nxt = LOAD;
`else
              w_led_nxt   = '0;
              w_state_nxt = FIN;
`endif
            end
          end
        end
        FIN: w_led_nxt = '0;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign reg_addr = r_addr;
  assign led      = r_led;
  assign dp       = (r_state != FIN);

  // Digit scan: r_digit is the digit currently lit, r_digit_nxt the one lit at the next wrap.
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_digit, r_digit_nxt;
  logic              r_lit;
  logic [7:0]        r_anode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit     <= '0;
      r_digit_nxt <= '0;
      r_lit       <= 1'b0;
      r_anode     <= 8'hFF;
    end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan_cnt  <= '0;
      r_digit     <= r_digit_nxt;
      r_digit_nxt <= r_digit_nxt + 3'd1;
      r_lit       <= 1'b1;
      r_anode     <= ~(8'd1 << r_digit_nxt);
    end else begin
      r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign anode = r_anode;

  logic [15:0] w_led16;
  logic [7:0]  w_addr8;
  logic [3:0]  w_chunk4;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic        w_hide_pos;
  logic [6:0]  w_seg;

  always_comb begin
    w_led16 = '0;
    for (int i = 0; i < LED_W && i < 16; i++) w_led16[i] = r_led[i];
  end

  assign w_addr8    = 8'(r_addr);
  assign w_chunk4   = 4'(r_chunk);
  assign w_hide_pos = (r_state == IDLE) || (r_state == MARK);

  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (r_digit)
      3'd0: w_nib = w_led16[3:0];
      3'd1: w_nib = w_led16[7:4];
      3'd2: w_nib = w_led16[11:8];
      3'd3: w_nib = w_led16[15:12];
      3'd4: begin w_nib = w_chunk4;     w_blank = w_hide_pos; end
      3'd5: w_blank = 1'b1;
      3'd6: begin w_nib = w_addr8[3:0]; w_blank = w_hide_pos; end
      3'd7: begin w_nib = w_addr8[7:4]; w_blank = w_hide_pos; end
      default: w_blank = 1'b1;
    endcase
  end

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'h7F;
    endcase
  end

  assign cathode = (!r_lit || w_blank) ? 7'h7F : w_seg;

endmodule
